// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch initiator with a small PC/instruction queue (optional FETCH_PERF_COUNTERS_EN)
module fetch_queue_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int QUEUE_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic                     imem_wEn,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_insn,
  output logic [ADDRESS_WIDTH-1:0] out_pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_full_stall
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [DATA_WIDTH-1:0]    insn_mem [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];

  logic pop;
  logic issue;
  logic not_empty;

  // The memory samples the PC on the falling edge, so the word returned by the
  // next rising edge always belongs to the current PC; no in-flight tracking.
  assign imem_addr = pc_q;
  assign imem_wEn  = 1'b0;

  assign not_empty = (count_q != '0);
  assign out_valid = not_empty & ~redirect_valid;
  assign out_insn  = not_empty ? insn_mem[head_q] : '0;
  assign out_pc    = not_empty ? pc_mem[head_q]   : '0;

  assign pop   = out_valid & out_ready;
  assign issue = ~reset & ~redirect_valid & ((count_q < DEPTH_C) | pop);

  // Next-state for PC, pointers and occupancy; redirect flushes and restarts.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({issue, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset overriding any redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage: capture the returned word with the PC that fetched it.
  always_ff @(posedge clk) begin
    if (issue) begin
      insn_mem[tail_q] <= imem_data;
      pc_mem[tail_q]   <= pc_q;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_full_stall_q;
  logic        full_stall;

  assign full_stall      = (count_q == DEPTH_C) & ~pop & ~redirect_valid;
  assign perf_fetched    = perf_fetched_q;
  assign perf_full_stall = perf_full_stall_q;

  // Saturating event counters; a redirect does not clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q    <= '0;
      perf_full_stall_q <= '0;
    end else begin
      if (issue && (perf_fetched_q != '1)) begin
        perf_fetched_q <= perf_fetched_q + 1'b1;
      end
      if (full_stall && (perf_full_stall_q != '1)) begin
        perf_full_stall_q <= perf_full_stall_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] imem_addr;
  logic        imem_wEn;
  logic [31:0] imem_data = 32'h0;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [11:0] out_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_full_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_queue_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_wEn       (imem_wEn),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_full_stall(perf_full_stall)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000 + i, updated on the falling edge.
  always @(negedge clk) imem_data <= 32'h1000 + {20'h0, imem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, insn} plus the fetch PC.
  typedef struct { int pc; int insn; } ent_t;
  ent_t mq[$];
  int   mpc;
  bit   mvalid = 0;
  int   m_fetched;
  int   m_stall;

  always @(negedge clk) begin
    bit   ev, mpop, miss;
    ent_t e;
    ev = (mq.size() != 0) && !redirect_valid;
    if (mvalid) begin
      chk("m_valid", {31'h0, out_valid}, {31'h0, ev});
      chk("m_addr", {20'h0, imem_addr}, mpc);
      chk("m_wen", {31'h0, imem_wEn}, 32'h0);
      chk("m_pc", {20'h0, out_pc}, (mq.size() != 0) ? mq[0].pc : 0);
      chk("m_insn", out_insn, (mq.size() != 0) ? mq[0].insn : 0);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("m_perf_fetched", perf_fetched, m_fetched);
      chk("m_perf_stall", perf_full_stall, m_stall);
`endif
    end
    mpop = ev && out_ready;
    miss = !reset && !redirect_valid && ((mq.size() < 4) || mpop);
    if (reset) begin
      mq.delete();
      mpc = 0;
      m_fetched = 0;
      m_stall = 0;
      mvalid = 1;
    end else if (mvalid) begin
      if (mq.size() == 4 && !mpop && !redirect_valid) m_stall++;
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc;
      end else begin
        if (mpop) void'(mq.pop_front());
        if (miss) begin
          e.pc = mpc;
          e.insn = 32'h1000 + mpc;
          mq.push_back(e);
          mpc = (mpc + 1) % 4096;
          m_fetched++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 1;
    step(); step();
    #1 chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_addr", {20'h0, imem_addr}, 0);
    chk("rst_insn", out_insn, 0);
    // stream after reset
    step(); reset = 0;
    #1 chk("c1_valid", {31'h0, out_valid}, 0);
    step();
    #1 chk("c2_valid", {31'h0, out_valid}, 1);
    chk("c2_pc", {20'h0, out_pc}, 0);
    chk("c2_insn", out_insn, 32'h1000);
    step();
    #1 chk("c3_pc", {20'h0, out_pc}, 1);
    chk("c3_insn", out_insn, 32'h1001);
    repeat (5) step();
    // backpressure from a fresh reset
    reset = 1; step(); reset = 0; out_ready = 0;
    repeat (10) step();
    #1 chk("bp_addr", {20'h0, imem_addr}, 4);
    chk("bp_pc", {20'h0, out_pc}, 0);
    chk("bp_valid", {31'h0, out_valid}, 1);
    // full with simultaneous pop
    step(); out_ready = 1;
    #1 chk("fp_pc", {20'h0, out_pc}, 0);
    step(); out_ready = 0;
    #1 chk("fp_next_pc", {20'h0, out_pc}, 1);
    chk("fp_addr", {20'h0, imem_addr}, 5);
    step(); out_ready = 1;
    repeat (8) step();
    // build three entries, then redirect mid-stream
    redirect_valid = 1; redirect_pc = 12'h100; out_ready = 0;
    step(); redirect_valid = 0;
    step(); step(); step();
    redirect_valid = 1; redirect_pc = 12'h200; out_ready = 1;
    #1 chk("rd_valid0", {31'h0, out_valid}, 0);
    step(); redirect_valid = 0;
    #1 chk("rd_valid1", {31'h0, out_valid}, 0);
    chk("rd_addr", {20'h0, imem_addr}, 12'h200);
    step();
    #1 chk("rd_pc0", {20'h0, out_pc}, 12'h200);
    step();
    #1 chk("rd_pc1", {20'h0, out_pc}, 12'h201);
    // address wrap-around
    step(); redirect_valid = 1; redirect_pc = 12'hFFE;
    step(); redirect_valid = 0;
    step();
    #1 chk("wr_pc0", {20'h0, out_pc}, 12'hFFE);
    step();
    #1 chk("wr_pc1", {20'h0, out_pc}, 12'hFFF);
    step();
    #1 chk("wr_pc2", {20'h0, out_pc}, 12'h000);
    chk("wr_insn2", out_insn, 32'h1000);
    step();
    #1 chk("wr_pc3", {20'h0, out_pc}, 12'h001);
    // back-to-back redirects: last wins
    step(); redirect_valid = 1; redirect_pc = 12'h300;
    step(); redirect_pc = 12'h340;
    step(); redirect_valid = 0;
    step();
    #1 chk("b2b_pc", {20'h0, out_pc}, 12'h340);
    // reset while full under backpressure
    out_ready = 0;
    repeat (8) step();
    reset = 1;
    step(); reset = 0;
    #1 chk("rf_valid", {31'h0, out_valid}, 0);
    chk("rf_addr", {20'h0, imem_addr}, 0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rf_perf_fetched", perf_fetched, 0);
    chk("rf_perf_stall", perf_full_stall, 0);
`endif
    out_ready = 1;
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
